// File: rtl/modred_pseudo_mersenne_if.sv
// rtl/modred_pseudo_mersenne_if.sv - operand/result handshake bundle for the pseudo-Mersenne reducer
interface modred_pseudo_mersenne_if #(
  parameter int W = 256
);
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] a;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   b;
  logic           busy;

  modport master (
    output in_valid, a, out_ready,
    input  in_ready, out_valid, b, busy
  );

  modport slave (
    input  in_valid, a, out_ready,
    output in_ready, out_valid, b, busy
  );
endinterface

// File: rtl/modred_pseudo_mersenne.sv
// rtl/modred_pseudo_mersenne.sv - sequential A mod (2^W - C) by shift-add folding plus one final subtract
// Optional MODRED_SKIP_ZERO_EN: ADD steps only over the set bits of C.
module modred_pseudo_mersenne #(
  parameter int           W   = 256,
  parameter logic [W-1:0] C   = 256'h1_000003D1,
  parameter int           C_W = 33
) (
  input  logic                    clk,
  input  logic                    rst_n,
  modred_pseudo_mersenne_if.slave bus
);

  localparam int IDX_W = (C_W > 1) ? $clog2(C_W) : 1;
  localparam logic [W-1:0] P = '0 - C;

  typedef enum logic [2:0] {S_IDLE, S_ADD, S_CHECK, S_SUB, S_DONE} state_t;

  state_t           state_q;
  logic [2*W-1:0]   acc_q;
  logic [W-1:0]     h_q;
  logic [IDX_W-1:0] idx_q;
  logic [W-1:0]     b_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [2*W-1:0]   acc_add_d;
  logic [IDX_W-1:0] idx_d;
  logic             add_en;

`ifdef MODRED_SKIP_ZERO_EN
  function automatic int low_set_bit();
    int r = 0;
    for (int i = C_W - 1; i >= 0; i--) if (C[i]) r = i;
    return r;
  endfunction

  function automatic int high_set_bit();
    int r = 0;
    for (int i = 0; i < C_W; i++) if (C[i]) r = i;
    return r;
  endfunction

  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(low_set_bit());
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(high_set_bit());

  assign add_en = 1'b1;

  // Lowest set bit of C strictly above the current position.
  always_comb begin
    idx_d = idx_q;
    for (int i = C_W - 1; i >= 0; i--) begin
      if (C[i] && (i > int'(idx_q))) idx_d = IDX_W'(i);
    end
  end
`else
  localparam logic [IDX_W-1:0] IDX_FIRST = '0;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(C_W - 1);

  assign add_en = C[idx_q];
  assign idx_d  = idx_q + IDX_W'(1);
`endif

  assign acc_add_d = acc_q + ({{W{1'b0}}, h_q} << idx_q);

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.b         = b_q;
  assign bus.busy      = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      h_q         <= '0;
      idx_q       <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            h_q     <= bus.a[2*W-1:W];
            acc_q   <= {{W{1'b0}}, bus.a[W-1:0]};
            idx_q   <= IDX_FIRST;
            busy_q  <= 1'b1;
            state_q <= S_ADD;
          end
        end
        S_ADD: begin
          if (add_en) acc_q <= acc_add_d;
          if (idx_q == IDX_LAST) state_q <= S_CHECK;
          else                   idx_q   <= idx_d;
        end
        S_CHECK: begin
          // 2^W == C (mod P): any carry into the high half gets folded again.
          if (|acc_q[2*W-1:W]) begin
            h_q     <= acc_q[2*W-1:W];
            acc_q   <= {{W{1'b0}}, acc_q[W-1:0]};
            idx_q   <= IDX_FIRST;
            state_q <= S_ADD;
          end else begin
            state_q <= S_SUB;
          end
        end
        S_SUB: begin
          b_q         <= (acc_q[W-1:0] >= P) ? (acc_q[W-1:0] - P) : acc_q[W-1:0];
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/modred_pseudo_mersenne.md
Name: modred_pseudo_mersenne

Overview:
- Parametrised sequential reducer: computes B = A mod P for a 2W-bit A and a pseudo-Mersenne prime P = 2^W - C (default secp256k1: W=256, C=2^32+977).
- Folds the high half into the low half using 2^W ≡ C, as one shifted add per cycle, repeating until the high half is zero.
- Finishes with one conditional subtraction, so the output is fully reduced to [0, P).
- Sits behind the field multiplier in the ECC datapath, with valid/ready on both sides.

Parameters:
- W, 256, field width in bits; A is 2W bits, B is W bits.
- C, 256'h1_000003D1, folding constant 2^W - P; must satisfy 0 < C < 2^(W-1).
- C_W, 33, bit width of C; must satisfy C_W+1 <= W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand a is valid.
- in_ready  out  1  block accepts an operand; equals (state==IDLE).
- a  in  2W  operand.
- out_valid  out  1  result b is valid (registered).
- out_ready  in  1  consumer accepts b.
- b  out  W  reduced result (registered).
- busy  out  1  high in any state other than IDLE (registered).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid=0, b=0, busy=0, acc=0, h=0, idx=0. in_ready=1 once rst_n=1.
- Registers:
  - acc, 2W bits.
  - h, W bits: the current high half being folded.
  - idx, clog2(C_W) bits: the current bit of C.
- IDLE: on in_valid && in_ready, capture h<=a[2W-1:W], acc<={W'b0, a[W-1:0]}, idx<=0, busy<=1, go to ADD.
- ADD: one cycle per bit position of C.
  - If C[idx]=1: acc<=acc+(h<<idx), zero-extended to 2W bits. No overflow is possible given the parameter constraints.
  - If idx==C_W-1: go to CHECK; otherwise idx<=idx+1.
- CHECK:
  - If acc[2W-1:W]!=0: h<=acc[2W-1:W], acc<={W'b0, acc[W-1:0]}, idx<=0, go to ADD (next fold).
  - Else go to SUB.
- SUB:
  - b <= (acc[W-1:0] >= P) ? acc[W-1:0]-P : acc[W-1:0], with P=2^W-C computed as a W-bit constant.
  - out_valid<=1; go to DONE.
  - One subtraction always suffices because acc < 2^W < 2P.
- DONE:
  - Hold b and out_valid stable while out_ready=0.
  - On out_ready=1: out_valid<=0, busy<=0, go to IDLE. in_ready rises the following cycle.
- Fold count F is data dependent; for the default parameters F ≤ 3.
- Latency, counted in clock edges from the accept edge to out_valid=1: F*(C_W+1)+2. Default with F=1: 36.
- in_valid while busy: ignored, not queued. Operand a is sampled only on the accept edge.
- out_ready high while not in DONE: ignored.
- Reset asserted mid-operation: the operation is aborted, no output is produced, and all outputs return to their reset values immediately.
- No back-to-back overlap: one operand in flight.

Optional Feature:
- Macro: MODRED_SKIP_ZERO_EN.
- When defined:
  - ADD visits only the set bits of C. A priority encoder over C masked above idx selects the next set bit.
  - idx starts at the lowest set bit of C; the last visited set bit transitions to CHECK.
  - Latency becomes F*(popcount(C)+1)+2. Default popcount=7: 10 for F=1.
- When undefined: all C_W positions are visited, as described in Behaviour.
- Results are bit-identical in both modes.

Test Plan:
- a=0, out_ready=1 -> b=0; out_valid rises 36 edges after accept (10 with MODRED_SKIP_ZERO_EN); busy high throughout.
- a={256'h0, P} -> b=0, exercising the SUB path. a={256'h0, P-1} -> b=P-1, no subtraction.
- a={256'h1, 256'h0} (i.e. 2^256) -> b=256'h1000003D1.
- a=(P-1)^2 -> b=1; F>1 observed via busy duration.
- a=2^512-1 -> b=256'h1_000007A2_000E90A0; check against a golden model on 1000 random operands with random out_ready stalls.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles after out_valid: b and out_valid stay stable, in_ready=0, and a second in_valid pulse is ignored.
  - Pulse rst_n=0 mid-ADD: out_valid=0, b=0, busy=0 immediately. in_ready=1 after release; the next operand reduces correctly.
